// File: rtl/layer_engine.sv
// ---------------------------------------------------------------------------
// layer_engine
//
// Serial evaluator for up to LAYER_DEPTH fully-connected layers of LAYER_SIZE
// neurons that share one neuron array. Layer 0 takes its input vector from a
// valid/ready sample stream. Each later layer takes its input from the
// activated results of the previous layer, which circulate through a shift
// register. The final layer's activated results leave through a valid/ready
// stream, neuron 0 first.
//
// Per layer the engine spends 1 cycle in CLEAR, LAYER_SIZE steps in ACCUM and
// 1 cycle in STORE. During ACCUM the engine presents (layer, node) to an
// external combinational weight store. The store returns one weight per
// neuron in the same cycle.
//
// Optional build macro: LAYER_BIAS_EN
//   When defined, the engine gains port b, which carries one signed bias per
//   neuron for the current layer. CLEAR preloads each accumulator with its
//   bias, aligned to the fixed-point format. When undefined, CLEAR zeroes the
//   accumulators.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle run request, sampled only while idle
//   num_layers  in   layer count for this run; 0 -> 1, values above
//                    LAYER_DEPTH are clamped to LAYER_DEPTH
//   in_data     in   signed input sample (consumed in layer 0 only)
//   in_valid    in   in_data valid
//   in_ready    out  engine accepts in_data
//   layer       out  weight-store layer address
//   node        out  weight-store input-index address
//   w           in   LAYER_SIZE signed weights; slice i drives neuron i
//   b           in   (LAYER_BIAS_EN only) LAYER_SIZE signed biases
//   out_data    out  activated result of the final layer
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts out_data
//   busy        out  high from start acceptance until the run ends
//   done        out  one-cycle pulse after the last output handshake
// ---------------------------------------------------------------------------
module layer_engine #(
    parameter int  LAYER_SIZE  = 4,
    parameter int  LAYER_DEPTH = 4,
    parameter int  BIT_SIZE    = 8,
    parameter int  FRAC_BITS   = 4,
    parameter int  ACT         = 1,
    localparam int NL_W        = $clog2(LAYER_DEPTH + 1),
    localparam int LY_W        = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1,
    localparam int ND_W        = $clog2(LAYER_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NL_W-1:0]                num_layers,
    input  logic [BIT_SIZE-1:0]            in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [LY_W-1:0]                layer,
    output logic [ND_W-1:0]                node,
    input  logic [LAYER_SIZE*BIT_SIZE-1:0] w,
`ifdef LAYER_BIAS_EN
    input  logic [LAYER_SIZE*BIT_SIZE-1:0] b,
`endif
    output logic [BIT_SIZE-1:0]            out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done
);

    // The accumulator is wide enough to hold LAYER_SIZE full-precision
    // products, so it cannot overflow inside a layer.
    localparam int ACC_W = 2 * BIT_SIZE + $clog2(LAYER_SIZE);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BIT_SIZE - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (BIT_SIZE - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_STORE,
        S_DRAIN
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic [NL_W-1:0]             layers_q;     // effective layer count of this run
    logic [NL_W-1:0]             layers_eff;   // num_layers after clamping

    logic signed [ACC_W-1:0]     acc     [LAYER_SIZE];
    logic signed [BIT_SIZE-1:0]  shifter [LAYER_SIZE];
    logic signed [BIT_SIZE-1:0]  w_arr   [LAYER_SIZE];
    logic signed [2*BIT_SIZE-1:0] prod   [LAYER_SIZE];
    logic signed [BIT_SIZE-1:0]  x_sel;

    logic                        first_layer;
    logic                        last_node;
    logic                        last_layer;
    logic                        beat;
    logic                        out_fire;

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------
    function automatic logic signed [BIT_SIZE-1:0] act_fn(
        input logic signed [BIT_SIZE-1:0] v
    );
        if ((ACT == 1) && (v < 0)) begin
            return '0;
        end
        return v;
    endfunction

    // Arithmetic shift floors the result toward minus infinity. The result is
    // then clamped into the signed BIT_SIZE range.
    function automatic logic signed [BIT_SIZE-1:0] sat_fn(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_BITS;
        if (s > SAT_MAX) begin
            return BIT_SIZE'(SAT_MAX);
        end
        if (s < SAT_MIN) begin
            return BIT_SIZE'(SAT_MIN);
        end
        return s[BIT_SIZE-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Combinational datapath
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < LAYER_SIZE; i++) begin
            w_arr[i] = $signed(w[i*BIT_SIZE +: BIT_SIZE]);
        end
    end

    always_comb begin
        if (num_layers == '0) begin
            layers_eff = NL_W'(1);
        end else if (num_layers > NL_W'(LAYER_DEPTH)) begin
            layers_eff = NL_W'(LAYER_DEPTH);
        end else begin
            layers_eff = num_layers;
        end
    end

    assign first_layer = (layer == '0);
    assign last_node   = (node == ND_W'(LAYER_SIZE - 1));
    assign last_layer  = ((NL_W'(layer) + NL_W'(1)) == layers_q);

    // Layer 0 advances only on a stream beat. Later layers read their operand
    // from the shifter, so they step every ACCUM cycle.
    assign beat     = (state == S_ACCUM) && (!first_layer || in_valid);
    assign out_fire = (state == S_DRAIN) && out_ready;

    // Layer 0 consumes raw samples. Later layers consume the activated output
    // of the previous layer.
    assign x_sel = first_layer ? $signed(in_data) : act_fn(shifter[0]);

    always_comb begin
        for (int i = 0; i < LAYER_SIZE; i++) begin
            prod[i] = x_sel * w_arr[i];
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments and an async
    // active-low reset, so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment up front keeps this block free of
        // inferred latches when no branch below fires.
        state_next = state;
        case (state)
            S_IDLE:  if (start)                state_next = S_CLEAR;
            S_CLEAR:                           state_next = S_ACCUM;
            S_ACCUM: if (beat && last_node)    state_next = S_STORE;
            S_STORE:                           state_next = last_layer ? S_DRAIN : S_CLEAR;
            S_DRAIN: if (out_fire && last_node) state_next = S_IDLE;
            default:                           state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_ACCUM: in_ready = first_layer;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = act_fn(shifter[0]);
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential datapath: addresses, accumulators, result shifter, done
    // -----------------------------------------------------------------------
    // NOTE: acc and shifter are small flop banks rather than RAM, so they take
    // the async reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer    <= '0;
            node     <= '0;
            layers_q <= '0;
            done     <= 1'b0;
            for (int i = 0; i < LAYER_SIZE; i++) begin
                acc[i]     <= '0;
                shifter[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        layers_q <= layers_eff;
                        layer    <= '0;
                        node     <= '0;
                    end
                end

                S_CLEAR: begin
                    node <= '0;
                    for (int i = 0; i < LAYER_SIZE; i++) begin
`ifdef LAYER_BIAS_EN
                        acc[i] <= ACC_W'($signed(b[i*BIT_SIZE +: BIT_SIZE])) <<< FRAC_BITS;
`else
                        acc[i] <= '0;
`endif
                    end
                end

                S_ACCUM: begin
                    if (beat) begin
                        node <= node + 1'b1;
                        for (int i = 0; i < LAYER_SIZE; i++) begin
                            acc[i] <= acc[i] + ACC_W'(prod[i]);
                        end
                        // Move the next input of this layer into slot 0.
                        if (!first_layer) begin
                            for (int i = 0; i < LAYER_SIZE - 1; i++) begin
                                shifter[i] <= shifter[i+1];
                            end
                            shifter[LAYER_SIZE-1] <= '0;
                        end
                    end
                end

                S_STORE: begin
                    node <= '0;
                    for (int i = 0; i < LAYER_SIZE; i++) begin
                        shifter[i] <= sat_fn(acc[i]);
                    end
                    if (!last_layer) begin
                        layer <= layer + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (out_fire) begin
                        for (int i = 0; i < LAYER_SIZE - 1; i++) begin
                            shifter[i] <= shifter[i+1];
                        end
                        shifter[LAYER_SIZE-1] <= '0;
                        if (last_node) begin
                            node <= '0;
                            done <= 1'b1;
                        end else begin
                            node <= node + 1'b1;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
